// File: rtl/vga_mem_arbiter.sv
// Shares one single-port frame memory between VGA scan-out reads (high priority) and pixel-writer writes.
// Optional macro VGA_ARB_STATS_EN adds 16-bit saturating grant counters with a synchronous clear.
module vga_mem_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 7,
  parameter int TIMEOUT    = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vblank,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err_timeout,
`ifdef VGA_ARB_STATS_EN
  input  logic              stat_clr,
  output logic [15:0]       stat_disp_grants,
  output logic [15:0]       stat_wr_grants,
  output logic [15:0]       stat_forced,
`endif
  output logic [1:0]        state_dbg
);

  // Handshake: a requester raises req with stable address/data and holds it until its ack,
  // a registered one-cycle pulse. Memory side: mem_req and its qualifiers stay constant until
  // a one-cycle mem_ack (or the timeout), then mem_req drops for at least one idle cycle.

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DISP_BUSY = 2'd1,
    WR_BUSY   = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tcnt;
  logic          starve_max;
  logic          wr_wins;
  logic          grant_disp, grant_wr, forced;
  logic          done, abort;

  assign starve_max = (starve_cnt == SW'(STARVE_MAX));
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // The winner is picked from the raw requests; if that winner is still acking it simply waits a
  // cycle rather than handing the slot to the other side, which keeps the 7:1 starvation cadence.
  always_comb begin
    state_next = state;
    wr_wins    = wr_req && (vblank || !disp_req || starve_max);
    grant_disp = 1'b0;
    grant_wr   = 1'b0;
    forced     = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_wins) begin
          if (!wr_ack) begin
            grant_wr   = 1'b1;
            forced     = !vblank && disp_req && starve_max;
            state_next = WR_BUSY;
          end
        end else if (disp_req && !disp_ack) begin
          grant_disp = 1'b1;
          state_next = DISP_BUSY;
        end
      end
      DISP_BUSY, WR_BUSY: begin
        if (mem_ack) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      disp_ack    <= 1'b0;
      wr_ack      <= 1'b0;
      disp_rdata  <= '0;
      err_timeout <= 1'b0;
      tcnt        <= '0;
    end else begin
      disp_ack <= 1'b0;
      wr_ack   <= 1'b0;
      if (grant_disp || grant_wr) begin
        mem_req   <= 1'b1;
        mem_we    <= grant_wr;
        mem_addr  <= grant_wr ? wr_addr : disp_addr;
        mem_wdata <= grant_wr ? wr_data : '0;
        tcnt      <= '0;
      end else if (done || abort) begin
        mem_req  <= 1'b0;
        disp_ack <= (state == DISP_BUSY);
        wr_ack   <= (state == WR_BUSY);
        if (state == DISP_BUSY) disp_rdata <= done ? mem_rdata : '0;
        if (abort) err_timeout <= 1'b1;
      end else if (state != IDLE) begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!wr_req || grant_wr) begin
      starve_cnt <= '0;
    end else if (grant_disp && !starve_max) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

`ifdef VGA_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_disp_grants <= '0;
      stat_wr_grants   <= '0;
      stat_forced      <= '0;
    end else if (stat_clr) begin
      stat_disp_grants <= '0;
      stat_wr_grants   <= '0;
      stat_forced      <= '0;
    end else begin
      if (grant_disp && stat_disp_grants != 16'hFFFF) stat_disp_grants <= stat_disp_grants + 16'd1;
      if (grant_wr && stat_wr_grants != 16'hFFFF)     stat_wr_grants   <= stat_wr_grants + 16'd1;
      if (forced && stat_forced != 16'hFFFF)          stat_forced      <= stat_forced + 16'd1;
    end
  end
`endif

endmodule

// File: doc/vga_mem_arbiter.md
Name: vga_mem_arbiter

Overview:
- Shares one single-port frame-memory interface between two requesters.
  - The VGA scan-out fetch path is high priority and deadline-bound.
  - The pixel writer (drawing engine) is low priority.
- Sits between the VGA controller's fetch logic and the memory controller.
- Sequences one access at a time with a req/ack handshake on each side.
- Gives the writer priority during vertical blank and guarantees it cannot starve during active video.

Parameters:
- ADDR_W, 18, memory word address width.
- DATA_W, 16, memory data width.
- STARVE_MAX, 7, consecutive display grants allowed while the writer waits before the writer is forced in.
- TIMEOUT, 63, cycles to wait for mem_ack before aborting an access.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- vblank  in  1  high during vertical blank (from the VGA counter).
- disp_req  in  1  display read request; held until disp_ack.
- disp_addr  in  ADDR_W  display read address; stable while disp_req is high.
- disp_ack  out  1  one-cycle pulse: display access complete.
- disp_rdata  out  DATA_W  read data; valid when disp_ack=1, holds until the next disp_ack.
- wr_req  in  1  writer request; held until wr_ack.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ack  out  1  one-cycle pulse: write complete.
- mem_req  out  1  memory access request.
- mem_we  out  1  1=write, 0=read; valid with mem_req.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
- mem_ack  in  1  one-cycle completion strobe from memory.
- err_timeout  out  1  sticky flag; set on any aborted access.

Behaviour:
- Reset values: all outputs 0, state=IDLE, starve_cnt=0, timeout counter=0, disp_rdata=0.
- States: IDLE, DISP_BUSY, WR_BUSY.
- IDLE arbitration, evaluated each cycle:
  - A requester whose ack is high this cycle is masked (one-cycle turnaround; no double service).
  - Winner selection:
    - If vblank=1: writer wins if wr_req=1, else display.
    - If vblank=0: display wins unless starve_cnt==STARVE_MAX and wr_req=1, in which case the writer wins.
  - On the next edge:
    - state goes to DISP_BUSY or WR_BUSY.
    - mem_req=1.
    - mem_addr, mem_we and mem_wdata are registered from the winner (mem_wdata=0 for reads).
- BUSY states:
  - mem_req, mem_addr, mem_we and mem_wdata are held constant.
  - On mem_ack=1:
    - mem_req=0 on the next edge and state goes to IDLE.
    - The matching ack pulses for exactly one cycle.
    - DISP_BUSY also captures mem_rdata into disp_rdata.
  - Latency: minimum 3 cycles from request to ack (memory acking in the cycle after mem_req rises); 2 cycles from mem_ack to a new mem_req.
- Starvation counter:
  - +1 on each display grant while wr_req=1, saturating at STARVE_MAX.
  - Cleared on a writer grant or whenever wr_req=0.
  - The rule applies regardless of vblank.
- Timeout:
  - The counter runs in BUSY states and clears on entry to BUSY.
  - If it reaches TIMEOUT without mem_ack:
    - mem_req drops.
    - The requester's ack pulses (disp_rdata=0 for a display access).
    - err_timeout is set; it clears only on reset.
    - state goes to IDLE.
- mem_ack while in IDLE is ignored.
- mem_ack on the same cycle as the timeout is treated as a normal completion; err_timeout is not set.
- Reset asserted mid-access forces IDLE immediately and clears mem_req asynchronously.
- Requesters may drop req before ack (a protocol violation): the access still completes and ack still pulses.

Optional Feature:
- Macro: VGA_ARB_STATS_EN.
- When defined, adds three 16-bit saturating output counters, all reset to 0:
  - stat_disp_grants: display grants.
  - stat_wr_grants: writer grants.
  - stat_forced: writer grants caused by starve_cnt==STARVE_MAX.
- Counters are cleared by a 1-bit input stat_clr (synchronous).
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Display read only, memory acks 1 cycle after mem_req, mem_rdata=16'hA5A5 -> mem_req high at cycle 1 with mem_we=0 and mem_addr=disp_addr; disp_ack pulse at cycle 3 with disp_rdata=16'hA5A5.
- disp_req and wr_req both held, vblank=0, STARVE_MAX=7 -> grant order is 7 display grants, then 1 writer grant; repeats; stat_forced increments once per cycle of 8 (with VGA_ARB_STATS_EN).
- Same stimulus with vblank=1 -> writer granted first; mem_we=1 and mem_wdata=wr_data on the writer access.
- Memory never acks, TIMEOUT=63 -> mem_req drops after 63 busy cycles; the requester's ack pulses; err_timeout=1 and stays 1 until rst=0.
- Assert rst=0 in the middle of WR_BUSY -> mem_req=0 immediately with no wr_ack; after release a pending wr_req is re-arbitrated from IDLE.
- Requester holds req one cycle after its ack -> no second mem_req for that requester from the masked cycle.
